// File: rtl/scan_fill.sv
// Scanline polygon filler: requests one span per scanline over a four-phase
// handshake, clips it to the screen, then streams one framebuffer write per pixel.
module scan_fill #(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int COLOR_W  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               go,
  input  logic [15:0]        y_top,
  input  logic [15:0]        y_bot,
  input  logic [COLOR_W-1:0] color,
  output logic               line_start,
  output logic [15:0]        line_y,
  input  logic               line_done,
  input  logic [15:0]        span_a,
  input  logic [15:0]        span_b,
  output logic               fb_we,
  output logic [15:0]        fb_x,
  output logic [15:0]        fb_y,
  output logic [COLOR_W-1:0] fb_data,
  input  logic               fb_ready,
  output logic               busy,
  output logic               fill_done
);

  localparam logic [15:0] X_MAX = 16'(SCREEN_W - 1);
  localparam logic [15:0] Y_MAX = 16'(SCREEN_H - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_REL,
    S_FILL,
    S_NEXT,
    S_FIN
  } state_t;

  state_t             r_state;
  logic [15:0]        r_cur_y;
  logic [15:0]        r_y_bot;
  logic [15:0]        r_sx;
  logic [15:0]        r_ex;
  logic               r_empty;
  logic [COLOR_W-1:0] r_color;

  logic               r_line_start;
  logic [15:0]        r_line_y;
  logic               r_fb_we;
  logic [15:0]        r_fb_x;
  logic [15:0]        r_fb_y;
  logic [COLOR_W-1:0] r_fb_data;
  logic               r_busy;
  logic               r_fill_done;

  logic [15:0]        w_y_bot_c;
  logic [15:0]        w_span_end;
  logic               w_span_empty;
  logic               w_last_x;
  logic               w_last_y;

  function automatic logic [15:0] clamp_u16(input logic [15:0] v, input logic [15:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  // Both y_bot and the span end are clamped so no write can leave the screen.
  assign w_y_bot_c    = clamp_u16(y_bot, Y_MAX);
  assign w_span_end   = clamp_u16(span_b, X_MAX);
  assign w_span_empty = (span_a > X_MAX);
  assign w_last_x     = (r_fb_x == r_ex);
  assign w_last_y     = (r_cur_y == r_y_bot);

  // The write position register doubles as the running x cursor.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_line_start <= 1'b0;
      r_line_y     <= '0;
      r_fb_we      <= 1'b0;
      r_fb_x       <= '0;
      r_fb_y       <= '0;
      r_fb_data    <= '0;
      r_busy       <= 1'b0;
      r_fill_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (go) begin
            r_cur_y <= y_top;
            r_y_bot <= w_y_bot_c;
            r_color <= color;
            r_busy  <= 1'b1;
            if (y_top > w_y_bot_c) begin
              r_state     <= S_FIN;
              r_fill_done <= 1'b1;
            end else begin
              r_state      <= S_REQ;
              r_line_start <= 1'b1;
              r_line_y     <= y_top;
            end
          end
        end
        S_REQ: begin
          if (line_done) begin
            r_sx         <= span_a;
            r_ex         <= w_span_end;
            r_empty      <= w_span_empty;
            r_line_start <= 1'b0;
            r_state      <= S_REL;
          end
        end
        S_REL: begin
          if (!line_done) begin
            if (r_empty) begin
              r_state <= S_NEXT;
            end else begin
              r_state   <= S_FILL;
              r_fb_we   <= 1'b1;
              r_fb_x    <= r_sx;
              r_fb_y    <= r_cur_y;
              r_fb_data <= r_color;
            end
          end
        end
        S_FILL: begin
          if (fb_ready) begin
            if (w_last_x) begin
              r_fb_we <= 1'b0;
              r_state <= S_NEXT;
            end else begin
              r_fb_x <= r_fb_x + 16'd1;
            end
          end
        end
        S_NEXT: begin
          if (w_last_y) begin
            r_state     <= S_FIN;
            r_fill_done <= 1'b1;
          end else begin
            r_cur_y      <= r_cur_y + 16'd1;
            r_line_y     <= r_cur_y + 16'd1;
            r_line_start <= 1'b1;
            r_state      <= S_REQ;
          end
        end
        S_FIN: begin
          r_fill_done <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign line_start = r_line_start;
  assign line_y     = r_line_y;
  assign fb_we      = r_fb_we;
  assign fb_x       = r_fb_x;
  assign fb_y       = r_fb_y;
  assign fb_data    = r_fb_data;
  assign busy       = r_busy;
  assign fill_done  = r_fill_done;

endmodule

// File: tb/tb_scan_fill.sv
// Directed bench for scan_fill: a four-phase span responder, a pixel scoreboard
// fed from the stimulus, and protocol monitors on the handshake and write bus.
module tb_scan_fill;

  logic        clk;
  logic        reset;
  logic        go;
  logic [15:0] y_top;
  logic [15:0] y_bot;
  logic [15:0] color;
  logic        line_start;
  logic [15:0] line_y;
  logic        line_done;
  logic [15:0] span_a;
  logic [15:0] span_b;
  logic        fb_we;
  logic [15:0] fb_x;
  logic [15:0] fb_y;
  logic [15:0] fb_data;
  logic        fb_ready;
  logic        busy;
  logic        fill_done;

  scan_fill #(.SCREEN_W(640), .SCREEN_H(480), .COLOR_W(16)) dut (
    .clk(clk), .reset(reset), .go(go), .y_top(y_top), .y_bot(y_bot), .color(color),
    .line_start(line_start), .line_y(line_y), .line_done(line_done),
    .span_a(span_a), .span_b(span_b), .fb_we(fb_we), .fb_x(fb_x), .fb_y(fb_y),
    .fb_data(fb_data), .fb_ready(fb_ready), .busy(busy), .fill_done(fill_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard of expected pixel writes {y, x, data}
  logic [47:0] exp_q[$];

  task automatic push_line(input int y, input int a, input int b, input logic [15:0] col);
    int e;
    if (a >= 640) return;
    e = (b > 639) ? 639 : b;
    for (int x = a; x <= e; x++) exp_q.push_back({16'(y), 16'(x), col});
  endtask

  // Span responder
  logic [15:0] tab_a[8];
  logic [15:0] tab_b[8];
  int          resp_delay = 0;
  int          resp_cnt = 0;
  bit          resp_hold = 0;
  int          hs_count = 0;
  logic [15:0] hs_y[$];

  initial begin
    line_done = 1'b0;
    span_a    = '0;
    span_b    = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!line_done) begin
        if (line_start) begin
          if (resp_cnt >= resp_delay) begin
            span_a    = tab_a[line_y[2:0]];
            span_b    = tab_b[line_y[2:0]];
            line_done = 1'b1;
            hs_count++;
            hs_y.push_back(line_y);
            resp_cnt  = 0;
          end else begin
            resp_cnt++;
          end
        end else begin
          resp_cnt = 0;
        end
      end else if (!line_start && !resp_hold) begin
        line_done = 1'b0;
      end
    end
  end

  // Framebuffer ready pattern: mode 1 gives 1,0,0,1,0,0,...
  int rdy_mode = 0;
  int rdy_ph = 0;
  initial begin
    fb_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 1) begin
        fb_ready = (rdy_ph == 0);
        rdy_ph   = (rdy_ph + 1) % 3;
      end else begin
        fb_ready = 1'b1;
        rdy_ph   = 0;
      end
    end
  end

  // Monitors, sampled mid-cycle
  int          wr_count = 0;
  int          fd_count = 0;
  int          ls_cycles = 0;
  int          overlap_cnt = 0;
  int          double_fd = 0;
  int          stall_checks = 0;
  logic        prev_ls = 1'b0;
  logic        prev_ld = 1'b0;
  logic        prev_fd = 1'b0;
  logic        prev_stall = 1'b0;
  logic [47:0] prev_word = '0;
  logic [47:0] exp_w;

  always @(negedge clk) begin
    if (fb_we === 1'b1 && fb_ready === 1'b1) begin
      wr_count++;
      chk("wr_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        exp_w = exp_q.pop_front();
        chk("wr_pixel", 64'({fb_y, fb_x, fb_data}), 64'(exp_w));
      end
    end
    if (prev_stall) begin
      stall_checks++;
      chk("stall_hold", 64'({fb_we, fb_y, fb_x, fb_data}), 64'({1'b1, prev_word}));
    end
    if (line_start === 1'b1 && !prev_ls) chk("ls_rise_vs_done", 64'(prev_ld), 64'd0);
    if (fb_we === 1'b1 && line_start === 1'b1) overlap_cnt++;
    if (fill_done === 1'b1) begin
      fd_count++;
      if (prev_fd) double_fd++;
    end
    if (line_start === 1'b1) ls_cycles++;
    prev_stall = (fb_we === 1'b1 && fb_ready === 1'b0);
    prev_word  = {fb_y, fb_x, fb_data};
    prev_ls    = (line_start === 1'b1);
    prev_ld    = line_done;
    prev_fd    = (fill_done === 1'b1);
  end

  // Fill runner
  logic first_ls, first_fd, first_busy;
  bit   timed_out;

  task automatic run_fill(input logic [15:0] yt, input logic [15:0] yb,
                          input logic [15:0] col, input int budget);
    int cyc;
    @(posedge clk);
    #1;
    y_top = yt;
    y_bot = yb;
    color = col;
    go    = 1'b1;
    @(posedge clk);
    #1;
    go = 1'b0;
    @(negedge clk);
    first_ls   = line_start;
    first_fd   = fill_done;
    first_busy = busy;
    cyc = 1;
    while (fill_done !== 1'b1 && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    timed_out = (fill_done !== 1'b1);
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int hs0, fd0, wr0, ls0, cyc;

  initial begin
    reset = 1'b1;
    go    = 1'b0;
    y_top = '0;
    y_bot = '0;
    color = '0;
    for (int i = 0; i < 8; i++) begin
      tab_a[i] = 16'd0;
      tab_b[i] = 16'd0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_line_start", 64'(line_start), 64'd0);
    chk("rst_line_y", 64'(line_y), 64'd0);
    chk("rst_fb_we", 64'(fb_we), 64'd0);
    chk("rst_fb_x", 64'(fb_x), 64'd0);
    chk("rst_fb_y", 64'(fb_y), 64'd0);
    chk("rst_fb_data", 64'(fb_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_fill_done", 64'(fill_done), 64'd0);
    reset = 1'b0;

    // Single line, span 5..8
    tab_a[2] = 16'd5; tab_b[2] = 16'd8;
    push_line(10, 5, 8, 16'hBEEF);
    hs0 = hs_count; fd0 = fd_count; hs_y.delete();
    run_fill(16'd10, 16'd10, 16'hBEEF, 100);
    chk("t1_timeout", 64'(timed_out), 64'd0);
    chk("t1_go_to_ls", 64'(first_ls), 64'd1);
    chk("t1_busy_early", 64'(first_busy), 64'd1);
    chk("t1_handshakes", 64'(hs_count - hs0), 64'd1);
    chk("t1_line_y", 64'((hs_y.size() > 0) ? hs_y[0] : 16'hFFFF), 64'd10);
    chk("t1_all_written", 64'(exp_q.size()), 64'd0);
    chk("t1_fd_pulses", 64'(fd_count - fd0), 64'd1);
    chk("t1_fd_low", 64'(fill_done), 64'd0);
    chk("t1_busy_end", 64'(busy), 64'd0);

    // Three lines, delayed responder, single pixel per line
    for (int i = 0; i < 3; i++) begin
      tab_a[i] = 16'd3; tab_b[i] = 16'd3;
      push_line(i, 3, 3, 16'h1234);
    end
    resp_delay = 4;
    hs0 = hs_count; wr0 = wr_count; hs_y.delete();
    run_fill(16'd0, 16'd2, 16'h1234, 200);
    resp_delay = 0;
    chk("t2_timeout", 64'(timed_out), 64'd0);
    chk("t2_handshakes", 64'(hs_count - hs0), 64'd3);
    chk("t2_line_y_seq", 64'((hs_y.size() == 3) ? {hs_y[0], hs_y[1], hs_y[2]} : 48'hFFFF),
        64'({16'd0, 16'd1, 16'd2}));
    chk("t2_writes", 64'(wr_count - wr0), 64'd3);
    chk("t2_all_written", 64'(exp_q.size()), 64'd0);

    // Horizontal clipping and an off-screen span
    tab_a[0] = 16'd630; tab_b[0] = 16'd700;
    tab_a[1] = 16'd650; tab_b[1] = 16'd660;
    tab_a[2] = 16'd0;   tab_b[2] = 16'd1;
    push_line(32, 630, 700, 16'h00AA);
    push_line(33, 650, 660, 16'h00AA);
    push_line(34, 0, 1, 16'h00AA);
    hs0 = hs_count; wr0 = wr_count;
    run_fill(16'd32, 16'd34, 16'h00AA, 300);
    chk("t3_timeout", 64'(timed_out), 64'd0);
    chk("t3_handshakes", 64'(hs_count - hs0), 64'd3);
    chk("t3_writes", 64'(wr_count - wr0), 64'd12);
    chk("t3_all_written", 64'(exp_q.size()), 64'd0);

    // Stalling framebuffer over span 0..3
    tab_a[2] = 16'd0; tab_b[2] = 16'd3;
    push_line(50, 0, 3, 16'h5A5A);
    rdy_mode = 1;
    wr0 = wr_count;
    run_fill(16'd50, 16'd50, 16'h5A5A, 200);
    rdy_mode = 0;
    chk("t4_timeout", 64'(timed_out), 64'd0);
    chk("t4_writes", 64'(wr_count - wr0), 64'd4);
    chk("t4_all_written", 64'(exp_q.size()), 64'd0);
    chk("t4_stalls_seen", 64'(stall_checks > 0), 64'd1);

    // Empty range: top below bottom
    hs0 = hs_count;
    run_fill(16'd20, 16'd5, 16'h0001, 10);
    chk("t5_fd_latency", 64'(first_fd), 64'd1);
    chk("t5_no_ls", 64'(first_ls), 64'd0);
    chk("t5_handshakes", 64'(hs_count - hs0), 64'd0);
    chk("t5_busy_end", 64'(busy), 64'd0);

    // Bottom clamped to the last screen row
    for (int i = 0; i < 8; i++) begin
      tab_a[i] = 16'd0; tab_b[i] = 16'd0;
    end
    for (int y = 470; y < 480; y++) push_line(y, 0, 0, 16'h0F0F);
    hs0 = hs_count; hs_y.delete();
    run_fill(16'd470, 16'd1000, 16'h0F0F, 500);
    chk("t6_timeout", 64'(timed_out), 64'd0);
    chk("t6_handshakes", 64'(hs_count - hs0), 64'd10);
    chk("t6_last_line_y", 64'((hs_y.size() > 0) ? hs_y[$] : 16'hFFFF), 64'd479);
    chk("t6_all_written", 64'(exp_q.size()), 64'd0);

    // Reset while filling at x=2 of span 0..9
    tab_a[4] = 16'd0; tab_b[4] = 16'd9;
    push_line(60, 0, 2, 16'hC0DE);
    wr0 = wr_count;
    @(posedge clk);
    #1;
    y_top = 16'd60; y_bot = 16'd60; color = 16'hC0DE; go = 1'b1;
    @(posedge clk);
    #1;
    go = 1'b0;
    cyc = 0;
    @(negedge clk);
    while (!(fb_we === 1'b1 && fb_x == 16'd2) && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("t7_reached_x2", 64'(fb_we === 1'b1 && fb_x == 16'd2), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t7_we_dropped", 64'(fb_we), 64'd0);
    chk("t7_busy_dropped", 64'(busy), 64'd0);
    repeat (10) @(negedge clk);
    chk("t7_writes", 64'(wr_count - wr0), 64'd3);
    chk("t7_all_written", 64'(exp_q.size()), 64'd0);

    // Go while busy is ignored
    tab_a[6] = 16'd0; tab_b[6] = 16'd0;
    push_line(70, 0, 0, 16'h7777);
    resp_delay = 6;
    hs0 = hs_count; fd0 = fd_count;
    @(posedge clk);
    #1;
    y_top = 16'd70; y_bot = 16'd70; color = 16'h7777; go = 1'b1;
    @(posedge clk);
    #1;
    go = 1'b0;
    @(posedge clk);
    #1;
    y_top = 16'd71; y_bot = 16'd75; color = 16'h9999; go = 1'b1;
    @(posedge clk);
    #1;
    go = 1'b0;
    cyc = 0;
    while (fd_count == fd0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    repeat (20) @(negedge clk);
    resp_delay = 0;
    chk("t8_handshakes", 64'(hs_count - hs0), 64'd1);
    chk("t8_fd_pulses", 64'(fd_count - fd0), 64'd1);
    chk("t8_busy_end", 64'(busy), 64'd0);
    chk("t8_all_written", 64'(exp_q.size()), 64'd0);

    // Reset mid-handshake with line_done still high afterwards
    tab_a[0] = 16'd0; tab_b[0] = 16'd0;
    @(posedge clk);
    #1;
    y_top = 16'd80; y_bot = 16'd80; color = 16'h8888; go = 1'b1;
    @(posedge clk);
    #1;
    go = 1'b0;
    cyc = 0;
    @(negedge clk);
    while (line_done !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("t9_done_seen", 64'(line_done), 64'd1);
    resp_hold = 1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ls0 = ls_cycles;
    repeat (6) @(negedge clk);
    chk("t9_no_ls_held_done", 64'(ls_cycles - ls0), 64'd0);
    chk("t9_busy_idle", 64'(busy), 64'd0);
    resp_hold = 0;
    repeat (4) @(negedge clk);
    chk("t9_no_ls_after", 64'(ls_cycles - ls0), 64'd0);
    chk("t9_busy_after", 64'(busy), 64'd0);

    // Whole-run protocol properties
    chk("no_we_ls_overlap", 64'(overlap_cnt), 64'd0);
    chk("fd_single_cycle", 64'(double_fd), 64'd0);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/scan_fill.md
SCAN_FILL -- requirements
Module: scan_fill

Interface
REQ-001 Parameter SCREEN_W, default 640, horizontal resolution in pixels.
REQ-002 Parameter SCREEN_H, default 480, vertical resolution in pixels.
REQ-003 Parameter COLOR_W, default 16, width of the fill colour.
REQ-004 clk  in  1  clock; all logic on posedge clk.
REQ-005 reset  in  1  reset, synchronous, active-high.
REQ-006 go  in  1  request to fill one polygon; sampled only in IDLE.
REQ-007 y_top, y_bot  in  16 each  first and last scanline to fill, in pixels; captured on accepted go.
REQ-008 color  in  COLOR_W  fill colour; captured on accepted go.
REQ-009 line_start  out  1  span request to the span calculator (four-phase).
REQ-010 line_y  out  16  scanline of the current request; stable while line_start=1.
REQ-011 line_done  in  1  span result valid; held high until line_start drops.
REQ-012 span_a, span_b  in  16 each  span endpoints in pixels, span_a <= span_b; valid while line_done=1.
REQ-013 fb_we  out  1  framebuffer pixel write valid.
REQ-014 fb_x, fb_y  out  16 each  pixel coordinates of the write.
REQ-015 fb_data  out  COLOR_W  pixel colour (captured color).
REQ-016 fb_ready  in  1  framebuffer accepts the write this cycle when fb_we=1.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 fill_done  out  1  one-cycle pulse when the polygon is complete.

Function
REQ-019 States: IDLE, REQ, REL, FILL, NEXT, FIN; no other states are reachable.
REQ-020 IDLE: go=1 captures y_top, min(y_bot, SCREEN_H-1), color; cur_y <= y_top; next state REQ; if captured y_top > clamped y_bot, next state FIN instead.
REQ-021 REQ: line_start=1, line_y=cur_y; on line_done=1 capture span_a/span_b into sx/ex, go to REL.
REQ-022 Capture clipping: if sx >= SCREEN_W the line is empty; else ex_c = min(ex, SCREEN_W-1).
REQ-023 REL: line_start=0; remain until line_done=0, then FILL if line non-empty, else NEXT.
REQ-024 line_start SHALL never rise while line_done=1 (strict four-phase ordering).
REQ-025 FILL: fb_we=1, fb_x=cur_x (initialised to sx), fb_y=cur_y, fb_data=color; cur_x advances by 1 only in cycles with fb_ready=1; outputs held stable while fb_ready=0.
REQ-026 FILL exits to NEXT in the cycle after the write with cur_x=ex_c is accepted; a span with sx=ex_c produces exactly one write.
REQ-027 Pixels per line = ex_c - sx + 1; no write outside x in [0,SCREEN_W-1], y in [0,SCREEN_H-1].
REQ-028 NEXT: if cur_y == clamped y_bot go to FIN; else cur_y <= cur_y+1, go to REQ.
REQ-029 FIN: fill_done=1 for exactly one cycle, then IDLE.
REQ-030 go while busy=1 is ignored and not queued.
REQ-031 Comparisons on y and x are unsigned 16-bit; cur_y increment never wraps because it stops at y_bot <= SCREEN_H-1.
REQ-032 Latency, no stalls: go to first line_start = 1 cycle; line_done=1 to line_start=0 = 1 cycle.
REQ-033 fb_we and line_start are never high in the same cycle.

Reset
REQ-034 reset=1 forces state IDLE next cycle from any state, including mid-FILL or mid-handshake.
REQ-035 Reset values: line_start=0, line_y=0, fb_we=0, fb_x=0, fb_y=0, fb_data=0, busy=0, fill_done=0.
REQ-036 After reset during REQ/REL the block SHALL wait in IDLE and not re-assert line_start until a new go; a line_done still high on leaving reset is ignored in IDLE.

Verification
REQ-037 y_top=10, y_bot=10, span 5..8, fb_ready=1 -> one handshake, writes (5,10),(6,10),(7,10),(8,10), then fill_done pulse, busy=0.
REQ-038 y_top=0, y_bot=2, spans 3..3 each line, responder delays done 4 cycles -> 3 handshakes with line_y 0,1,2, 3 writes at x=3, no line_start while line_done=1.
REQ-039 span 630..700, SCREEN_W=640 -> writes x=630..639 only; span 650..660 -> zero writes, proceeds to next line.
REQ-040 fb_ready toggling 1,0,0,1,... over span 0..3 -> each x written exactly once, fb_x/fb_y/fb_data stable during stalls.
REQ-041 y_top=20, y_bot=5 -> no line_start, fill_done one cycle after go; y_bot=1000 -> last line_y=479.
REQ-042 reset asserted mid-FILL at x=2 of span 0..9 -> fb_we=0 next cycle, IDLE, no further writes until next go; go during busy ignored.
